// File: rtl/bk_adder_pipe.sv
// Two-stage pipelined Brent-Kung adder/subtractor with valid/ready handshake
// and a carry register so that wide operands can be streamed as chained beats.
module bk_adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LG = $clog2(WIDTH);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s1_chain_q, s1_chain_d;
  logic             s1_sub_q, s1_sub_d;
  logic             s1_cin_q, s1_cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             carry_q, carry_d;

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] gg;
  logic [WIDTH-1:0] pp;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | adv;
  assign accept   = in_valid & in_ready;

  // Stage 1: propagate/generate capture and carry-in selection flags
  always_comb begin
    b_eff      = in_sub ? ~in_b : in_b;
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_chain_d = s1_chain_q;
    s1_sub_d   = s1_sub_q;
    s1_cin_d   = s1_cin_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_p_d     = in_a ^ b_eff;
      s1_g_d     = in_a & b_eff;
      s1_chain_d = in_chain;
      s1_sub_d   = in_sub;
      s1_cin_d   = in_cin;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: Brent-Kung prefix tree; after both sweeps gg[i]/pp[i] span bits 0..i
  always_comb begin
    gg = s1_g_q;
    pp = s1_p_q;
    for (int l = 0; l < LG; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    for (int l = LG - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= 3 * (1 << l) - 1) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
  end

  // Green cells fold the selected carry-in into every group prefix
  always_comb begin
    cin_eff = s1_chain_q ? carry_q : (s1_sub_q ? 1'b1 : s1_cin_q);
    c[0]    = cin_eff;
    for (int i = 0; i < WIDTH; i++) begin
      c[i + 1] = gg[i] | (pp[i] & cin_eff);
    end
    sum = s1_p_q ^ c[WIDTH-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    carry_d     = carry_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sum_d  = sum;
        out_cout_d = c[WIDTH];
        out_ovf_d  = c[WIDTH] ^ c[WIDTH-1];
        carry_d    = c[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_chain_q  <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_chain_q  <= s1_chain_d;
      s1_sub_q    <= s1_sub_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: three widths (4, 8, 32) run side by side against an
// arithmetic scoreboard model, plus hand-computed directed cases at width 8.
module tb_bk_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv, ordy, cin, sub, chn;
  logic [2:0]  irdy, ov, cout, ovf;
  logic [3:0]  a4, b4, s4;
  logic [7:0]  a8, b8, s8;
  logic [31:0] a32, b32, s32;

  int          total, bad;
  logic [33:0] sb [3][16];
  int          wp [3];
  int          rp [3];
  int          acc [3];
  int          base [3];
  logic        mc [3];

  bk_adder_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(a4), .in_b(b4), .in_cin(cin[0]), .in_sub(sub[0]), .in_chain(chn[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s4),
    .out_cout(cout[0]), .out_ovf(ovf[0]));

  bk_adder_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(a8), .in_b(b8), .in_cin(cin[1]), .in_sub(sub[1]), .in_chain(chn[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s8),
    .out_cout(cout[1]), .out_ovf(ovf[1]));

  bk_adder_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_a(a32), .in_b(b32), .in_cin(cin[2]), .in_sub(sub[2]), .in_chain(chn[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s32),
    .out_cout(cout[2]), .out_ovf(ovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wid(int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 32);
  endfunction

  function automatic logic [31:0] get_a(int k);
    case (k)
      0:       return {28'd0, a4};
      1:       return {24'd0, a8};
      default: return a32;
    endcase
  endfunction

  function automatic logic [31:0] get_b(int k);
    case (k)
      0:       return {28'd0, b4};
      1:       return {24'd0, b8};
      default: return b32;
    endcase
  endfunction

  function automatic logic [31:0] get_s(int k);
    case (k)
      0:       return {28'd0, s4};
      1:       return {24'd0, s8};
      default: return s32;
    endcase
  endfunction

  // Reference: {ovf, cout, sum} = A + B' + cin as plain wide integer arithmetic
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                        logic ci, logic su, logic ch, logic mcy);
    logic [63:0] mask, aa, bb, full, sm;
    logic        c, co, o;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = (su ? ~{32'd0, b} : {32'd0, b}) & mask;
    c    = ch ? mcy : (su ? 1'b1 : ci);
    full = aa + bb + {63'd0, c};
    sm   = full & mask;
    co   = full[w];
    o    = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
    return {o, co, sm[31:0]};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic ch);
    case (k)
      0:       begin a4 = a[3:0]; b4 = b[3:0]; end
      1:       begin a8 = a[7:0]; b8 = b[7:0]; end
      default: begin a32 = a; b32 = b; end
    endcase
    cin[k] = c;
    sub[k] = s;
    chn[k] = ch;
  endtask

  // Scoreboard step at the falling edge: compare held outputs, then log accepts
  task automatic observe();
    logic [33:0] e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        wp[k] = 0;
        rp[k] = 0;
        mc[k] = 1'b0;
      end else begin
        if (ov[k]) begin
          if (wp[k] == rp[k]) begin
            chk($sformatf("unexpected_out_w%0d", wid(k)), 40'(ov[k]), 40'd0);
          end else begin
            chk($sformatf("result_w%0d", wid(k)),
                {6'd0, ovf[k], cout[k], get_s(k)}, {6'd0, sb[k][rp[k] % 16]});
            if (ordy[k]) rp[k]++;
          end
        end
        if (iv[k] && irdy[k]) begin
          e = model(wid(k), get_a(k), get_b(k), cin[k], sub[k], chn[k], mc[k]);
          sb[k][wp[k] % 16] = e;
          wp[k]++;
          mc[k] = e[32];
          acc[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic out8(input string name, input logic [10:0] exp);
    chk(name, {29'd0, ov[1], cout[1], ovf[1], s8}, {29'd0, exp});
  endtask

  task automatic one8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic su, input logic ch, input logic [10:0] exp);
    set_in(1, {24'd0, a}, {24'd0, b}, ci, su, ch);
    iv[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    tick();
    out8(name, exp);
  endtask

  initial begin
    int bp_base;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    iv    = '0;
    ordy  = 3'b111;
    cin   = '0;
    sub   = '0;
    chn   = '0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    for (int k = 0; k < 3; k++) begin
      wp[k] = 0; rp[k] = 0; acc[k] = 0; base[k] = 0; mc[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_w%0d", wid(k)),
          {4'd0, irdy[k], ov[k], cout[k], ovf[k], get_s(k)}, {4'd0, 4'b1000, 32'd0});
    end
    rst_n = 1'b1;
    tick();

    // expected fields: {out_valid, out_cout, out_ovf, out_sum}
    one8("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, {1'b1, 1'b1, 1'b0, 8'h00});
    one8("sub_neg",   8'h05, 8'h07, 1'b0, 1'b1, 1'b0, {1'b1, 1'b0, 1'b0, 8'hFE});
    one8("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 1'b0, {1'b1, 1'b1, 1'b1, 8'h7F});
    one8("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 8'h80});
    one8("add_cin",   8'h10, 8'h20, 1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 8'h31});

    // back-to-back chained addition 0x00FF + 0x0001
    set_in(1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0);
    iv[1] = 1'b1;
    tick();
    set_in(1, 32'h00, 32'h00, 1'b0, 1'b0, 1'b1);
    tick();
    iv[1] = 1'b0;
    out8("chain_add_lo", {1'b1, 1'b1, 1'b0, 8'h00});
    tick();
    out8("chain_add_hi", {1'b1, 1'b0, 1'b0, 8'h01});

    // chained subtraction 0x0100 - 0x0001
    set_in(1, 32'h00, 32'h01, 1'b0, 1'b1, 1'b0);
    iv[1] = 1'b1;
    tick();
    set_in(1, 32'h01, 32'h00, 1'b0, 1'b1, 1'b1);
    tick();
    iv[1] = 1'b0;
    out8("chain_sub_lo", {1'b1, 1'b0, 1'b0, 8'hFF});
    tick();
    out8("chain_sub_hi", {1'b1, 1'b1, 1'b0, 8'h00});
    tick();

    // backpressure: consumer stalls four edges while three beats are offered
    bp_base = wp[1];
    ordy[1] = 1'b0;
    set_in(1, 32'h10, 32'h01, 1'b0, 1'b0, 1'b0);
    iv[1] = 1'b1;
    tick();
    set_in(1, 32'h20, 32'h02, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1, 32'h30, 32'h03, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_in_ready", 40'(irdy[1]), 40'd0);
    out8("bp_hold_1", {1'b1, 1'b0, 1'b0, 8'h11});
    tick();
    out8("bp_hold_2", {1'b1, 1'b0, 1'b0, 8'h11});
    chk("bp_accepts", 40'(wp[1] - bp_base), 40'd2);
    ordy[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    out8("bp_flow_2", {1'b1, 1'b0, 1'b0, 8'h22});
    tick();
    out8("bp_flow_3", {1'b1, 1'b0, 1'b0, 8'h33});
    tick();
    chk("bp_empty", 40'(ov[1]), 40'd0);

    // reset with both stages full and carry_q set
    ordy[1] = 1'b0;
    set_in(1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0);
    iv[1] = 1'b1;
    tick();
    tick();
    iv[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {38'd0, irdy[1], ov[1]}, {38'd0, 2'b10});
    tick();
    rst_n   = 1'b1;
    ordy[1] = 1'b1;
    one8("chain_after_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 8'h00});
    tick();

    // random traffic on all three widths
    for (int k = 0; k < 3; k++) base[k] = acc[k];
    for (int cyc = 0; cyc < 18000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom % 10) < 8;
        ordy[k] = ($urandom % 10) < 8;
        set_in(k, $urandom, $urandom, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      end
      tick();
    end
    iv   = '0;
    ordy = 3'b111;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain_w%0d", wid(k)), 40'(wp[k] - rp[k]), 40'd0);
      chk($sformatf("beats_w%0d", wid(k)), 40'((acc[k] - base[k]) >= 10000), 40'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
